// File: rtl/cv32e40p_voter_pkg.sv
// rtl/cv32e40p_voter_pkg.sv - shared types and helpers for the replicated-output voter
package cv32e40p_voter_pkg;

  typedef enum logic [1:0] {H_OK, H_SUSPECT, H_FAILED} health_e;
  typedef enum logic {VM_TMR, VM_DMR} vote_mode_e;

  // Consecutive-flag counter width; covers the full ERR_TH range 1..255.
  localparam int unsigned HCNT_W = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cv32e40p_voter_health_fsm.sv
// rtl/cv32e40p_voter_health_fsm.sv - per-replica OK/SUSPECT/FAILED tracker
// FAILED is sticky until clear_i; fail_inh_i parks the replica in SUSPECT at threshold.
module cv32e40p_voter_health_fsm
  import cv32e40p_voter_pkg::*;
#(
  parameter int unsigned ERR_TH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flag_i,
  input  logic              upd_en_i,
  input  logic              clear_i,
  input  logic              fail_inh_i,
  output health_e           state_o,
  output logic [HCNT_W-1:0] cnt_o
);

  localparam logic [HCNT_W-1:0] TH = HCNT_W'(ERR_TH);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_o <= H_OK;
      cnt_o   <= '0;
    end else if (upd_en_i) begin
      case (state_o)
        H_OK: begin
          if (flag_i) begin
            if (ERR_TH == 1 && !fail_inh_i) begin
              state_o <= H_FAILED;
              cnt_o   <= TH;
            end else begin
              state_o <= H_SUSPECT;
              cnt_o   <= HCNT_W'(1);
            end
          end
        end
        H_SUSPECT: begin
          if (!flag_i) begin
            state_o <= H_OK;
            cnt_o   <= '0;
          end else if (({1'b0, cnt_o} + 9'd1) >= {1'b0, TH}) begin
            cnt_o <= TH;
            if (!fail_inh_i) state_o <= H_FAILED;
          end else begin
            cnt_o <= cnt_o + HCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_nvoter_ctrl.sv
// rtl/cv32e40p_nvoter_ctrl.sv - registered NCH-channel TMR voter degrading to DMR on replica failure
// Optional per-replica saturating flag counters: CV32E40P_NVOTER_ERRCNT_EN.
module cv32e40p_nvoter_ctrl
  import cv32e40p_voter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NCH    = 1,
  parameter int unsigned ERR_TH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [NCH-1:0][WIDTH-1:0]  in_1_i,
  input  logic [NCH-1:0][WIDTH-1:0]  in_2_i,
  input  logic [NCH-1:0][WIDTH-1:0]  in_3_i,
  input  logic                       clear_i,
  output logic                       valid_o,
  output logic [NCH-1:0][WIDTH-1:0]  voted_o,
  output logic [2:0]                 err_detected_o,
  output logic                       err_corrected_o,
  output logic                       err_uncorrectable_o,
  output logic [2:0]                 repl_failed_o,
  output logic                       dmr_mode_o,
  output logic [2:0][CNT_W-1:0]      err_cnt_o
);

  health_e                  st   [3];
  logic [HCNT_W-1:0]        hcnt [3];
  logic [2:0]               failed;
  logic [2:0]               fail_req;
  vote_mode_e               mode;
  logic [NCH-1:0][WIDTH-1:0] vote_d;
  logic [2:0]               flags_d;
  logic                     unc_d;
  logic                     upd_en;
  logic                     fail_inh;

  assign mode          = (|failed) ? VM_DMR : VM_TMR;
  assign dmr_mode_o    = (mode == VM_DMR);
  assign repl_failed_o = failed;

  always_comb begin
    logic [WIDTH-1:0] a, b, c, m, x, y;
    logic [2:0]       pair;
    vote_d  = '0;
    flags_d = '0;
    unc_d   = 1'b0;
    a = '0; b = '0; c = '0; m = '0; x = '0; y = '0;
    pair = 3'b011;
    for (int ch = 0; ch < NCH; ch++) begin
      a = in_1_i[ch];
      b = in_2_i[ch];
      c = in_3_i[ch];
      if (mode == VM_TMR) begin
        for (int i = 0; i < WIDTH; i++) m[i] = maj3(a[i], b[i], c[i]);
        // No two replicas agree: there is no majority word, so fall back to replica 1.
        if (a != b && a != c && b != c) begin
          vote_d[ch] = a;
          unc_d      = 1'b1;
          flags_d    = flags_d | {c != a, b != a, 1'b0};
        end else begin
          vote_d[ch] = m;
          flags_d    = flags_d | {c != m, b != m, a != m};
        end
      end else begin
        if (failed[0]) begin
          x = b; y = c; pair = 3'b110;
        end else if (failed[1]) begin
          x = a; y = c; pair = 3'b101;
        end else begin
          x = a; y = b; pair = 3'b011;
        end
        vote_d[ch] = x;
        if (x != y) begin
          unc_d   = 1'b1;
          flags_d = flags_d | pair;
        end
      end
    end
  end

  assign upd_en = valid_i & ~unc_d;
  // Only one replica may ever be excluded: block failure in DMR or on a simultaneous pair.
  assign fail_inh = dmr_mode_o | maj3(fail_req[0], fail_req[1], fail_req[2]);

  for (genvar k = 0; k < 3; k++) begin : g_fsm
    cv32e40p_voter_health_fsm #(
      .ERR_TH (ERR_TH)
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flag_i     (flags_d[k]),
      .upd_en_i   (upd_en),
      .clear_i    (clear_i),
      .fail_inh_i (fail_inh),
      .state_o    (st[k]),
      .cnt_o      (hcnt[k])
    );
    assign failed[k]   = (st[k] == H_FAILED);
    assign fail_req[k] = upd_en & flags_d[k] &
                         (((st[k] == H_OK) && (ERR_TH == 1)) ||
                          ((st[k] == H_SUSPECT) &&
                           (({1'b0, hcnt[k]} + 9'd1) >= 9'(ERR_TH))));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o             <= 1'b0;
      voted_o             <= '0;
      err_detected_o      <= '0;
      err_corrected_o     <= 1'b0;
      err_uncorrectable_o <= 1'b0;
    end else begin
      valid_o             <= valid_i;
      if (valid_i) voted_o <= vote_d;
      err_detected_o      <= valid_i ? flags_d : 3'b000;
      err_corrected_o     <= valid_i & (|flags_d) & ~unc_d;
      err_uncorrectable_o <= valid_i & unc_d;
    end
  end

`ifdef CV32E40P_NVOTER_ERRCNT_EN
  logic [2:0][CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (valid_i) begin
      for (int k = 0; k < 3; k++) begin
        if (flags_d[k] && err_cnt_q[k] != {CNT_W{1'b1}})
          err_cnt_q[k] <= err_cnt_q[k] + CNT_W'(1);
      end
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: doc/cv32e40p_nvoter_ctrl.md
# cv32e40p_nvoter_ctrl

Registered, multi-channel triple-modular-redundancy voter with per-replica health tracking for the fault-tolerant cv32e40p. Votes NCH independent WIDTH-bit channels from three replicas each valid cycle. Identifies a persistently faulty replica and excludes it, degrading from TMR to DMR under its own control rather than through an external mode pin. Sits between replicated pipeline-stage outputs and the downstream stage, with status outputs feeding the fault-reporting logic.

## Interface
- WIDTH, 32: bits per channel.
- NCH, 1: number of independently voted channels.
- ERR_TH, 4: consecutive flagged samples before a replica is declared failed; range 1..255.
- CNT_W, 8: width of the per-replica total error counters.
- clk_i  input  1  clock.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  replica inputs valid this cycle.
- in_1_i / in_2_i / in_3_i  input  [NCH-1:0][WIDTH-1:0]  replica values.
- clear_i  input  1  one-cycle pulse; returns all replicas to healthy.
- valid_o  output  1  voted result valid.
- voted_o  output  [NCH-1:0][WIDTH-1:0]  voted value.
- err_detected_o  output  [2:0]  bit k set: replica k+1 disagreed with the vote on at least one channel.
- err_corrected_o  output  1  mismatch present, and the majority is correct on every channel.
- err_uncorrectable_o  output  1  no majority on at least one channel.
- repl_failed_o  output  [2:0]  replica excluded from voting.
- dmr_mode_o  output  1  one replica has failed; voting is between the remaining two.
- err_cnt_o  output  [2:0][CNT_W-1:0]  saturating total flag count per replica.

## Operation
- **TMR mode, per channel:**
  - Majority of the three inputs is the output.
  - A replica is flagged if it differs from the majority on any channel.
  - If all three inputs differ on a channel, that channel outputs in_1_i and err_uncorrectable_o is set.
- **DMR mode, per channel:**
  - Only the two healthy replicas are compared.
  - The output is the lower-indexed healthy replica.
  - A mismatch sets err_uncorrectable_o and flags both healthy replicas.
- **Health FSM, one per replica, states OK / SUSPECT / FAILED:**
  - Updates only on valid_i samples with no uncorrectable condition. An uncorrectable sample holds the state and the consecutive count.
  - OK to SUSPECT on flag; the consecutive count is set to 1.
  - SUSPECT: a flag increments the count. When the count reaches ERR_TH the replica goes to FAILED. An unflagged sample returns it to OK and zeroes the count.
  - ERR_TH=1 goes from OK straight to FAILED on the first flag.
  - FAILED is sticky until clear_i or reset.
- **Failure limits:**
  - At most one replica may be FAILED; in DMR mode no further FAILED transitions occur.
  - If two replicas would reach FAILED on the same edge, neither transitions; both stay SUSPECT with the count saturated at ERR_TH.
- **clear_i:** all FSMs go to OK, counts are zeroed and dmr_mode_o is cleared on the next edge. err_cnt_o is not cleared.
- **clear_i together with valid_i:** the sample is voted in the current mode, and the clear takes priority over that sample's FSM update.

## Timing
- Latency 1. A sample accepted at edge t appears on valid_o, voted_o and all err_* outputs after edge t+1.
- Without valid_i, valid_o=0 and voted_o holds its last value.
- err_* outputs are 0 whenever valid_o=0.
- An FSM transition caused by the sample at t takes effect in the vote of the sample at t+1. repl_failed_o and dmr_mode_o update with the same edge as that sample's valid_o.
- Reset forces all outputs to 0, all FSMs to OK and all counts to 0; dmr_mode_o=0 (TMR).
- Reset mid-stream drops any sample in flight: valid_o=0 on the following cycle.

## Configuration
- CV32E40P_NVOTER_ERRCNT_EN:
  - Defined: err_cnt_o[k] increments by 1 on every valid sample that flags replica k, including uncorrectable samples. It saturates at 2^CNT_W-1.
  - Undefined: the counters are not built and err_cnt_o is tied to 0.

## Structure
- Package cv32e40p_voter_pkg holds:
  - health_e {H_OK, H_SUSPECT, H_FAILED}.
  - vote_mode_e {VM_TMR, VM_DMR}.
  - Function maj3 (bitwise majority).
- Sub-module cv32e40p_voter_health_fsm, instantiated three times:
  - Inputs: flag, update enable, clear, fail-inhibit.
  - Outputs: state, count.

## Test plan
- Equal inputs 0xA5A5A5A5 with valid_i for 10 cycles: voted_o=0xA5A5A5A5 one cycle later; all error outputs 0.
- in_2 differs for 1 cycle (ERR_TH=4): err_detected_o=3'b010 and err_corrected_o=1; replica 2 goes OK, then SUSPECT, then back to OK; repl_failed_o stays 0.
- in_3 wrong on 4 consecutive samples:
  - repl_failed_o=3'b100 and dmr_mode_o=1 after the 4th result.
  - A 5th sample with a wrong in_3 gives voted_o=in_1 and err_detected_o=0.
- DMR mode with in_1≠in_2: err_uncorrectable_o=1, voted_o=in_1, err_detected_o=3'b011, no new FAILED.
- All three inputs differ on channel 1 of NCH=2 while channel 0 agrees: err_uncorrectable_o=1, channel 1 outputs in_1, FSM counts unchanged.
- clear_i asserted in the same cycle as the 4th wrong sample: no FAILED transition, all FSMs OK; err_cnt_o[2]=4 with the macro defined, 0 without.
